// File: rtl/mem_port_master.sv
// Initiator for the unified single-port inst/data memory: arbitrates IF fetches
// against MEM load/stores, checks data accesses and returns results with valid pulses.
module mem_port_master #(
    parameter int ADDR_W    = 9,
    parameter int MEM_BYTES = 512,
    parameter int DATA_BASE = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_valid,
    output logic [31:0]       if_inst,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [2:0]        ls_f3,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_ready,
    output logic              ls_rvalid,
    output logic [31:0]       ls_rdata,
    output logic              ls_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_addr2,
    output logic [2:0]        mem_f3,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_inst,
    input  logic [31:0]       mem_rdata,
    output logic              stall
);

    typedef enum logic [2:0] {IDLE, ISSUE_I, ISSUE_D, RESP_I, RESP_D, ERR_D} state_t;

    localparam logic [ADDR_W+1:0] BASE_W  = DATA_BASE[ADDR_W+1:0];
    localparam logic [ADDR_W+1:0] LIMIT_W = MEM_BYTES[ADDR_W+1:0];

    state_t            state;
    logic              last_data;
    logic              store_q;
    logic              grant_i, grant_d;
    logic [ADDR_W+1:0] size;
    logic [ADDR_W+1:0] end_addr;
    logic              bad_f3, misal, oor, ls_bad;

    // last_data breaks ties so both classes alternate under contention
    assign grant_i  = (state == IDLE) && if_req && (!ls_req || last_data);
    assign grant_d  = (state == IDLE) && ls_req && (!if_req || !last_data);
    assign if_ready = grant_i;
    assign ls_ready = grant_d;

    always_comb begin
        size = '0;
        case (ls_f3[1:0])
            2'b00:   size = (ADDR_W+2)'(1);
            2'b01:   size = (ADDR_W+2)'(2);
            default: size = (ADDR_W+2)'(4);
        endcase
    end

    assign bad_f3   = (ls_f3[1:0] == 2'b11) || (ls_f3[2] && ls_f3[1]);
    assign misal    = ((ls_f3[1:0] == 2'b01) && ls_addr[0]) ||
                      ((ls_f3[1:0] == 2'b10) && (ls_addr[1:0] != 2'b00));
    assign end_addr = BASE_W + {2'b00, ls_addr} + size;
    assign oor      = end_addr > LIMIT_W;
    assign ls_bad   = bad_f3 || misal || oor;

    // memory data_out is only valid during RESP_D, so load data passes straight through
    assign ls_rdata = (state == RESP_D && !store_q) ? mem_rdata : 32'd0;

    assign stall = (if_req && !if_ready) || (ls_req && !ls_ready) || (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last_data <= 1'b1;
            store_q   <= 1'b0;
            if_valid  <= 1'b0;
            if_inst   <= '0;
            ls_rvalid <= 1'b0;
            ls_err    <= 1'b0;
            mem_addr  <= '0;
            mem_addr2 <= '0;
            mem_f3    <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        mem_addr  <= {if_addr[ADDR_W-1:2], 2'b00};
                        last_data <= 1'b0;
                        state     <= ISSUE_I;
                    end else if (grant_d) begin
                        last_data <= 1'b1;
                        if (ls_bad) begin
                            ls_rvalid <= 1'b1;
                            ls_err    <= 1'b1;
                            state     <= ERR_D;
                        end else begin
                            mem_addr2 <= ls_addr;
                            mem_f3    <= ls_f3;
                            mem_wdata <= ls_wdata;
                            mem_read  <= !ls_we;
                            mem_write <= ls_we;
                            store_q   <= ls_we;
                            state     <= ISSUE_D;
                        end
                    end
                end
                ISSUE_I: begin
                    if_inst  <= mem_inst;
                    if_valid <= 1'b1;
                    state    <= RESP_I;
                end
                ISSUE_D: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    ls_rvalid <= 1'b1;
                    state     <= RESP_D;
                end
                RESP_I: begin
                    if_valid <= 1'b0;
                    state    <= IDLE;
                end
                RESP_D, ERR_D: begin
                    ls_rvalid <= 1'b0;
                    ls_err    <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_master.sv
// Randomized bench for mem_port_master with a word-array memory stub and a
// rule-based model of acceptance, error classification and response timing.
module tb_mem_port_master;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ready, if_valid;
    logic [31:0]   if_inst;
    logic          ls_req = 1'b0, ls_we = 1'b0;
    logic [2:0]    ls_f3 = '0;
    logic [AW-1:0] ls_addr = '0;
    logic [31:0]   ls_wdata = '0;
    logic          ls_ready, ls_rvalid, ls_err;
    logic [31:0]   ls_rdata;
    logic [AW-1:0] mem_addr, mem_addr2;
    logic [2:0]    mem_f3;
    logic          mem_read, mem_write;
    logic [31:0]   mem_wdata, mem_inst;
    logic [31:0]   mem_rdata = '0;
    logic          stall;

    int total = 0;
    int bad   = 0;

    logic [31:0] inst_mem [0:127];
    logic [31:0] data_mem [0:511];

    mem_port_master #(.ADDR_W(AW), .MEM_BYTES(512), .DATA_BASE(200)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_valid(if_valid), .if_inst(if_inst),
        .ls_req(ls_req), .ls_we(ls_we), .ls_f3(ls_f3), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_rvalid(ls_rvalid),
        .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_addr(mem_addr), .mem_addr2(mem_addr2), .mem_f3(mem_f3),
        .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_inst(mem_inst), .mem_rdata(mem_rdata), .stall(stall)
    );

    always #5 clk = ~clk;

    assign mem_inst = inst_mem[mem_addr[AW-1:2]];
    always @(posedge clk) if (mem_read) mem_rdata <= data_mem[mem_addr2];

    // Reference rules: legal func3 set, natural alignment, region bound
    function automatic bit exp_err(input logic [2:0] f3, input int a);
        int sz;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (a % sz != 0) return 1'b1;
        if (200 + a + sz > 512) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_fetch(input logic [AW-1:0] a, input string nm);
        logic [31:0]   exp_inst;
        logic [AW-1:0] exp_addr;
        exp_inst = inst_mem[a / 4];
        exp_addr = (a / 4) * 4;
        @(negedge clk);
        if_req = 1'b1; if_addr = a;
        #1;
        total++;
        if ({if_ready, ls_ready} !== 2'b10) begin
            bad++; $display("FAIL %s accept: got %b want 10", nm, {if_ready, ls_ready});
        end
        @(posedge clk); #1;
        if_req = 1'b0; if_addr = AW'($urandom);
        @(negedge clk);
        total++;
        if ({mem_addr, mem_read, mem_write, if_valid, stall} !== {exp_addr, 4'b0001}) begin
            bad++; $display("FAIL %s issue: addr=%h rd=%b wr=%b v=%b st=%b want addr=%h 0001",
                            nm, mem_addr, mem_read, mem_write, if_valid, stall, exp_addr);
        end
        @(negedge clk);
        total++;
        if ({if_valid, if_inst, mem_read, mem_write} !== {1'b1, exp_inst, 2'b00}) begin
            bad++; $display("FAIL %s resp: v=%b inst=%h rd=%b wr=%b want 1 %h", nm, if_valid,
                            if_inst, mem_read, mem_write, exp_inst);
        end
        @(negedge clk);
        total++;
        if (if_valid !== 1'b0) begin
            bad++; $display("FAIL %s pulse: if_valid=%b want 0", nm, if_valid);
        end
    endtask

    task automatic do_ls(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                         input logic [31:0] wd, input string nm);
        bit          e;
        logic [31:0] exp_rd;
        e      = exp_err(f3, int'(a));
        exp_rd = we ? 32'd0 : data_mem[a];
        @(negedge clk);
        ls_req = 1'b1; ls_we = we; ls_f3 = f3; ls_addr = a; ls_wdata = wd;
        #1;
        total++;
        if ({if_ready, ls_ready} !== 2'b01) begin
            bad++; $display("FAIL %s accept: got %b want 01", nm, {if_ready, ls_ready});
        end
        @(posedge clk); #1;
        ls_req = 1'b0; ls_we = 1'($urandom); ls_f3 = 3'($urandom);
        ls_addr = AW'($urandom); ls_wdata = $urandom;
        @(negedge clk);
        total++;
        if (e) begin
            if ({ls_rvalid, ls_err, ls_rdata, mem_read, mem_write} !== {2'b11, 32'd0, 2'b00}) begin
                bad++; $display("FAIL %s err: v=%b e=%b rd=%h r=%b w=%b want 1 1 0 0 0", nm,
                                ls_rvalid, ls_err, ls_rdata, mem_read, mem_write);
            end
        end else begin
            if ({mem_read, mem_write, mem_addr2, mem_f3, ls_rvalid} !== {!we, we, a, f3, 1'b0}) begin
                bad++; $display("FAIL %s issue: r=%b w=%b a2=%h f3=%b v=%b want %b %b %h %b 0",
                                nm, mem_read, mem_write, mem_addr2, mem_f3, ls_rvalid, !we, we, a, f3);
            end
            if (we) begin
                total++;
                if (mem_wdata !== wd) begin
                    bad++; $display("FAIL %s wdata: got %h want %h", nm, mem_wdata, wd);
                end
            end
            @(negedge clk);
            total++;
            if ({ls_rvalid, ls_err, ls_rdata, mem_read, mem_write} !== {2'b10, exp_rd, 2'b00}) begin
                bad++; $display("FAIL %s resp: v=%b e=%b rd=%h r=%b w=%b want 1 0 %h 0 0", nm,
                                ls_rvalid, ls_err, ls_rdata, mem_read, mem_write, exp_rd);
            end
        end
        @(negedge clk);
        total++;
        if ({ls_rvalid, ls_err} !== 2'b00) begin
            bad++; $display("FAIL %s pulse: v=%b e=%b want 00", nm, ls_rvalid, ls_err);
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({if_valid, if_inst, ls_rvalid, ls_err, ls_rdata, mem_addr, mem_addr2, mem_f3,
             mem_read, mem_write, mem_wdata, stall} !== '0) begin
            bad++; $display("FAIL reset_outputs: some output nonzero (if_inst=%h mem_addr=%h)",
                            if_inst, mem_addr);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        total++;
        if ({if_ready, ls_ready, stall} !== 3'b000) begin
            bad++; $display("FAIL reset_idle: got %b want 000", {if_ready, ls_ready, stall});
        end
    endtask

    task automatic test_directed();
        inst_mem[4] = 32'h0020E233;
        data_mem[4] = 32'd13;
        do_fetch(9'h010, "fetch_010");
        do_fetch(9'h013, "fetch_unaligned_forced");
        do_ls(1'b0, 3'b010, 9'd4, 32'd0, "load_word");
        do_ls(1'b1, 3'b001, 9'd12, 32'h1234, "store_half");
        do_ls(1'b0, 3'b010, 9'd2, 32'd0, "err_word_mis");
        do_ls(1'b0, 3'b001, 9'd311, 32'd0, "err_half_311");
        do_ls(1'b0, 3'b011, 9'd0, 32'd0, "err_f3_011");
        do_ls(1'b0, 3'b110, 9'd0, 32'd0, "err_f3_110");
        do_ls(1'b0, 3'b010, 9'd308, 32'd0, "word_last");
        do_ls(1'b1, 3'b010, 9'd312, 32'hAA, "word_oor");
        do_ls(1'b0, 3'b100, 9'd311, 32'd0, "byte_last");
        do_ls(1'b0, 3'b101, 9'd310, 32'd0, "half_last");
    endtask

    task automatic test_contention();
        bit ei, ed;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        if_req = 1'b1; if_addr = 9'h020;
        ls_req = 1'b1; ls_we = 1'b0; ls_f3 = 3'b010; ls_addr = 9'd8;
        for (int c = 0; c < 12; c++) begin
            #1;
            ei = (c % 3 == 0) && ((c / 3) % 2 == 0);
            ed = (c % 3 == 0) && ((c / 3) % 2 == 1);
            total++;
            if ({if_ready, ls_ready, stall} !== {ei, ed, 1'b1}) begin
                bad++; $display("FAIL contention cyc%0d: got %b want %b", c,
                                {if_ready, ls_ready, stall}, {ei, ed, 1'b1});
            end
            @(negedge clk);
        end
        if_req = 1'b0; ls_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_f3 = 3'b010; ls_addr = 9'd16; ls_wdata = 32'hCAFE0001;
        @(posedge clk); #1;
        ls_req = 1'b0;
        @(negedge clk);
        total++;
        if (mem_write !== 1'b1) begin
            bad++; $display("FAIL midop_issue: mem_write=%b want 1", mem_write);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({mem_write, mem_read, ls_rvalid, stall} !== 4'b0000) begin
            bad++; $display("FAIL midop_reset: got %b want 0000",
                            {mem_write, mem_read, ls_rvalid, stall});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b1;
            total++;
            if (ls_rvalid !== 1'b0) begin
                bad++; $display("FAIL midop_novalid%0d: ls_rvalid=%b want 0", i, ls_rvalid);
            end
        end
        do_ls(1'b0, 3'b000, 9'd33, 32'd0, "post_reset_load");
        do_fetch(9'h044, "post_reset_fetch");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0)
                do_fetch(AW'($urandom), "rand_fetch");
            else
                do_ls(1'($urandom), 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 1) != 0) ? AW'($urandom_range(296, 315))
                                                  : AW'($urandom_range(0, 511)),
                      $urandom, "rand_ls");
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) inst_mem[i] = $urandom;
        for (int i = 0; i < 512; i++) data_mem[i] = $urandom;
        test_reset();
        test_directed();
        test_contention();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
